writeback_arbiter: RTL and testbench

Parametrised writeback stage for the RISC-V pipeline. It accepts completed results from NCH producer channels (main memory stage plus multicycle units) through per-channel FIFOs, and round-robin arbitrates them onto the single register-file write port. Each commit is registered as a `writeback_data_t` record, and retired instructions are counted. It replaces the pass-through writeback between `memory_data_t` and `writeback_data_t`.

---
 rtl/writeback_arbiter_pkg.sv | 50 +++++
 rtl/writeback_arbiter_fifo.sv | 50 +++++
 rtl/writeback_arbiter.sv | 117 +++++++++++
 tb/tb_writeback_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared writeback types: word and pipeline record layouts plus the channel limit.
// wb_fwd_t only exists when WB_FORWARD_EN is defined.
package writeback_arbiter_pkg;

  localparam int WB_MAX_NCH = 8;
  localparam int XLEN       = 32;

  typedef logic [XLEN-1:0] word_t;

  typedef struct packed {
    word_t      pc;
    word_t      instruction;
    logic [6:0] op;
    logic       jump;
    logic       regwrite;
    logic [4:0] dst;
    word_t      regdata;
  } memory_data_t;

  typedef struct packed {
    word_t      pc;
    word_t      instruction;
    logic [6:0] op;
    logic       jump;
    logic       regwrite;
    logic [4:0] dst;
    word_t      regdata;
  } writeback_data_t;

`ifdef WB_FORWARD_EN
  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    word_t      data;
  } wb_fwd_t;
`endif

  function automatic writeback_data_t toWriteback(input memory_data_t m);
    writeback_data_t w;
    w.pc          = m.pc;
    w.instruction = m.instruction;
    w.op          = m.op;
    w.jump        = m.jump;
    w.regwrite    = m.regwrite;
    w.dst         = m.dst;
    w.regdata     = m.regdata;
    return w;
  endfunction

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// Per-channel result FIFO: registered occupancy count, full/empty flags,
// flush clears pointers without touching the storage array.
module wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  memory_data_t pushData,
  output memory_data_t headData,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  memory_data_t     mem [DEPTH];
  logic [AW-1:0]    rdPtr;
  logic [AW-1:0]    wrPtr;
  logic [AW:0]      count;
  logic             doPush;
  logic             doPop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign doPush   = resetn && push && !full && !flush;
  assign doPop    = pop && !empty && !flush;
  assign headData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback stage: NCH producer FIFOs round-robin arbitrated onto the register-file port.
// Define WB_FORWARD_EN to add the combinational fwd_* bypass outputs.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic [NCH-1:0]  in_valid,
  output logic [NCH-1:0]  in_ready,
  input  memory_data_t    in_data [NCH],
  output logic            wb_valid,
  output writeback_data_t dataW,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output word_t           rf_wdata,
  output logic [63:0]     commit_cnt
`ifdef WB_FORWARD_EN
  ,
  output logic            fwd_valid,
  output logic [4:0]      fwd_dst,
  output word_t           fwd_data
`endif
);

  localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]   full;
  logic [NCH-1:0]   empty;
  logic [NCH-1:0]   pop;
  memory_data_t     headData [NCH];
  logic [PTR_W-1:0] rrPtr;
  logic [PTR_W-1:0] grantIdx;
  logic [PTR_W-1:0] cand;
  logic [PTR_W-1:0] nextPtr;
  logic             grantValid;

  // Stage p0: channel FIFOs, ready depends only on registered occupancy
  assign in_ready = (resetn && !flush) ? ~full : '0;

  for (genvar i = 0; i < NCH; i++) begin : gCh
    wb_fifo #(.DEPTH(DEPTH)) uFifo (
      .clk      (clk),
      .resetn   (resetn),
      .flush    (flush),
      .push     (in_valid[i] && in_ready[i]),
      .pop      (pop[i]),
      .pushData (in_data[i]),
      .headData (headData[i]),
      .full     (full[i]),
      .empty    (empty[i])
    );
  end

  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    cand       = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = PTR_W'((int'(rrPtr) + k) % NCH);
      if (!grantValid && !empty[cand]) begin
        grantValid = 1'b1;
        grantIdx   = cand;
      end
    end
    if (flush) grantValid = 1'b0;
  end

  always_comb begin
    pop = '0;
    if (grantValid) pop[grantIdx] = 1'b1;
  end

  assign nextPtr = (int'(grantIdx) == NCH - 1) ? '0 : grantIdx + 1'b1;

  // Stage p1: commit register and retirement counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rrPtr      <= '0;
      wb_valid   <= 1'b0;
      dataW      <= '0;
      commit_cnt <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      dataW    <= '0;
    end else if (grantValid) begin
      rrPtr      <= nextPtr;
      wb_valid   <= 1'b1;
      dataW      <= toWriteback(headData[grantIdx]);
      commit_cnt <= commit_cnt + 64'd1;
    end else begin
      wb_valid <= 1'b0;
    end
  end

  // x0 commits still retire but never reach the register file
  assign rf_we    = wb_valid && dataW.regwrite && (dataW.dst != 5'd0);
  assign rf_waddr = dataW.dst;
  assign rf_wdata = dataW.regdata;

`ifdef WB_FORWARD_EN
  memory_data_t granted;
  wb_fwd_t      fwd;

  assign granted   = headData[grantIdx];
  assign fwd       = '{valid: grantValid && granted.regwrite && (granted.dst != 5'd0),
                       dst:   granted.dst,
                       data:  granted.regdata};
  assign fwd_valid = fwd.valid;
  assign fwd_dst   = fwd.dst;
  assign fwd_data  = fwd.data;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed table, corner sequences, and random traffic
// checked against a queue-based model of the arbitration rules.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  localparam int NCH   = 2;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            resetn;
  logic            flush;
  logic [NCH-1:0]  inValid;
  logic [NCH-1:0]  inReady;
  memory_data_t    inData [NCH];
  logic            wbValid;
  writeback_data_t dataW;
  logic            rfWe;
  logic [4:0]      rfWaddr;
  word_t           rfWdata;
  logic [63:0]     commitCnt;

  always #5 clk = ~clk;

  writeback_arbiter #(.NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .in_data    (inData),
    .wb_valid   (wbValid),
    .dataW      (dataW),
    .rf_we      (rfWe),
    .rf_waddr   (rfWaddr),
    .rf_wdata   (rfWdata),
    .commit_cnt (commitCnt)
  );

  // reference model state
  memory_data_t    mq [NCH][$];
  int              mRr;
  logic [63:0]     mCnt;
  logic            mWbv;
  writeback_data_t mData;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int rn, fl, v;
    int dst0, dat0, rw0;
    int dst1, dat1, rw1;
    int eWbv, eWe, eAddr, eData, eCnt;
  } vec_t;

  vec_t tbl [12];
  memory_data_t z;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic memory_data_t mk(input logic [4:0] dst, input word_t val, input logic rw);
    memory_data_t m;
    m.pc          = $urandom;
    m.instruction = $urandom;
    m.op          = 7'($urandom);
    m.jump        = 1'($urandom);
    m.regwrite    = rw;
    m.dst         = dst;
    m.regdata     = val;
    return m;
  endfunction

  // One clock: drive at negedge, check ready before the edge, advance the model, check outputs after.
  task automatic step(input logic rn, input logic fl, input logic [NCH-1:0] v,
                      input memory_data_t d0, input memory_data_t d1);
    logic [NCH-1:0] expRdy;
    int g;
    resetn    = rn;
    flush     = fl;
    inValid   = v;
    inData[0] = d0;
    inData[1] = d1;
    for (int i = 0; i < NCH; i++) expRdy[i] = rn && !fl && (mq[i].size() < DEPTH);
    #1;
    check("in_ready", 128'(inReady), 128'(expRdy));
    @(posedge clk);
    if (!rn) begin
      for (int i = 0; i < NCH; i++) mq[i].delete();
      mRr = 0; mCnt = '0; mWbv = 1'b0; mData = '0;
    end else if (fl) begin
      for (int i = 0; i < NCH; i++) mq[i].delete();
      mWbv = 1'b0; mData = '0;
    end else begin
      g = -1;
      for (int k = 0; k < NCH; k++)
        if (g < 0 && mq[(mRr + k) % NCH].size() > 0) g = (mRr + k) % NCH;
      if (g >= 0) begin
        mData = writeback_data_t'(mq[g].pop_front());
        mWbv  = 1'b1;
        mCnt  = mCnt + 64'd1;
        mRr   = (g + 1) % NCH;
      end else begin
        mWbv = 1'b0;
      end
      for (int i = 0; i < NCH; i++)
        if (v[i] && expRdy[i]) mq[i].push_back(i == 0 ? d0 : d1);
    end
    #1;
    check("wb_valid",   128'(wbValid),   128'(mWbv));
    check("rf_we",      128'(rfWe),      128'(mWbv && mData.regwrite && (mData.dst != 5'd0)));
    check("rf_waddr",   128'(rfWaddr),   128'(mData.dst));
    check("rf_wdata",   128'(rfWdata),   128'(mData.regdata));
    check("commit_cnt", 128'(commitCnt), 128'(mCnt));
    check("dataW",      128'(dataW),     128'(mData));
    @(negedge clk);
  endtask

  initial begin
    logic sawFull;
    z = '0;
    mRr = 0; mCnt = '0; mWbv = 1'b0; mData = '0;
    resetn = 1'b0; flush = 1'b0; inValid = '0; inData[0] = '0; inData[1] = '0;

    //          rn fl v  dst0 dat0    rw0 dst1 dat1  rw1 wbv we addr data    cnt
    tbl[0]  = '{0, 0, 0, 0,   0,      0,  0,   0,    0,  0,  0, 0,   0,      0};
    tbl[1]  = '{1, 0, 1, 5,   'h1234, 1,  0,   0,    0,  0,  0, 0,   0,      0};
    tbl[2]  = '{1, 0, 0, 0,   0,      0,  0,   0,    0,  1,  1, 5,   'h1234, 1};
    tbl[3]  = '{1, 0, 0, 0,   0,      0,  0,   0,    0,  0,  0, 5,   'h1234, 1};
    tbl[4]  = '{1, 0, 1, 0,   'hBEEF, 1,  0,   0,    0,  0,  0, 5,   'h1234, 1};
    tbl[5]  = '{1, 0, 0, 0,   0,      0,  0,   0,    0,  1,  0, 0,   'hBEEF, 2};
    tbl[6]  = '{1, 0, 3, 3,   'h11,   1,  4,   'h22, 1,  0,  0, 0,   'hBEEF, 2};
    tbl[7]  = '{1, 0, 0, 0,   0,      0,  0,   0,    0,  1,  1, 4,   'h22,   3};
    tbl[8]  = '{1, 0, 0, 0,   0,      0,  0,   0,    0,  1,  1, 3,   'h11,   4};
    tbl[9]  = '{1, 0, 0, 0,   0,      0,  0,   0,    0,  0,  0, 3,   'h11,   4};
    tbl[10] = '{1, 0, 2, 0,   0,      0,  7,   'h77, 0,  0,  0, 3,   'h11,   4};
    tbl[11] = '{1, 0, 0, 0,   0,      0,  0,   0,    0,  1,  0, 7,   'h77,   5};

    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      step(1'(tbl[i].rn), 1'(tbl[i].fl), 2'(tbl[i].v),
           mk(5'(tbl[i].dst0), tbl[i].dat0, 1'(tbl[i].rw0)),
           mk(5'(tbl[i].dst1), tbl[i].dat1, 1'(tbl[i].rw1)));
      check($sformatf("tbl%0d_wbv", i),  128'(wbValid),   128'(tbl[i].eWbv));
      check($sformatf("tbl%0d_we", i),   128'(rfWe),      128'(tbl[i].eWe));
      check($sformatf("tbl%0d_addr", i), 128'(rfWaddr),   128'(tbl[i].eAddr));
      check($sformatf("tbl%0d_data", i), 128'(rfWdata),   128'(tbl[i].eData));
      check($sformatf("tbl%0d_cnt", i),  128'(commitCnt), 128'(tbl[i].eCnt));
    end

    // round robin: three entries per channel drain as ch0,ch1,ch0,ch1,ch0,ch1
    step(1'b0, 1'b0, 2'b00, z, z);
    for (int j = 0; j < 7; j++) begin
      if (j < 3) step(1'b1, 1'b0, 2'b11, mk(5'(2*j+1), $urandom, 1'b1), mk(5'(2*j+2), $urandom, 1'b1));
      else       step(1'b1, 1'b0, 2'b00, z, z);
      if (j > 0) begin
        check("rr_valid", 128'(wbValid), 128'(1));
        check("rr_dst",   128'(rfWaddr), 128'(j));
      end
    end

    // full FIFO back-pressure and ready recovery
    step(1'b0, 1'b0, 2'b00, z, z);
    sawFull = 1'b0;
    for (int j = 0; j < 10; j++) begin
      step(1'b1, 1'b0, 2'b11, mk(5'($urandom), $urandom, 1'b1), mk(5'($urandom), $urandom, 1'b1));
      if (!inReady[1]) sawFull = 1'b1;
    end
    check("full_seen", 128'(sawFull), 128'(1));
    for (int j = 0; j < 6; j++) step(1'b1, 1'b0, 2'b00, z, z);
    check("full_drained_ready", 128'(inReady), 128'(2'b11));

    // flush with two entries buffered and a concurrent push
    step(1'b0, 1'b0, 2'b00, z, z);
    step(1'b1, 1'b0, 2'b01, mk(5'd1, 32'h1, 1'b1), z);
    step(1'b1, 1'b0, 2'b11, mk(5'd2, 32'h2, 1'b1), mk(5'd3, 32'h3, 1'b1));
    check("pre_flush_valid", 128'(wbValid), 128'(1));
    step(1'b1, 1'b1, 2'b11, mk(5'd4, 32'h4, 1'b1), mk(5'd5, 32'h5, 1'b1));
    check("flush_valid", 128'(wbValid), 128'(0));
    for (int j = 0; j < 3; j++) begin
      step(1'b1, 1'b0, 2'b00, z, z);
      check("post_flush_valid", 128'(wbValid), 128'(0));
    end
    check("flush_cnt_kept", 128'(commitCnt), 128'(1));

    // reset mid-stream
    for (int j = 0; j < 4; j++)
      step(1'b1, 1'b0, 2'b11, mk(5'($urandom), $urandom, 1'b1), mk(5'($urandom), $urandom, 1'b1));
    step(1'b0, 1'b0, 2'b11, mk(5'd8, 32'h8, 1'b1), mk(5'd8, 32'h8, 1'b1));
    check("rst_cnt",   128'(commitCnt), 128'(0));
    check("rst_valid", 128'(wbValid),   128'(0));
    check("rst_dataW", 128'(dataW),     128'(0));
    check("rst_rfwe",  128'(rfWe),      128'(0));
    step(1'b1, 1'b0, 2'b11, mk(5'd9, 32'h9, 1'b1), mk(5'd10, 32'hA, 1'b1));
    step(1'b1, 1'b0, 2'b00, z, z);
    check("rst_first_ch0", 128'(rfWaddr), 128'(9));
    step(1'b1, 1'b0, 2'b00, z, z);
    check("rst_then_ch1",  128'(rfWaddr), 128'(10));

    // random traffic against the model
    for (int j = 0; j < 600; j++) begin
      step(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 24) == 0), 2'($urandom),
           mk(5'($urandom), $urandom, 1'($urandom)), mk(5'($urandom), $urandom, 1'($urandom)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
